tcdm_sram_adapter: RTL and testbench
====================================

Name: tcdm_sram_adapter

Overview:
- Slave-side endpoint of the TCDM bus: takes the flattened slave signals (req/add/wen/wdata/be -> gnt/r_rdata/r_opc/r_valid) and drives one single-port SRAM bank.
- SRAM bank has configurable read latency.
- Sits directly downstream of the TCDM crossbar slave port, one instance per bank.
- Generates the response channel through a latency-matched valid pipeline and keeps per-bank access counters for profiling.

Parameters:
- MEM_ADDR_W, 10, SRAM word-address width (bank depth = 2^MEM_ADDR_W 32-bit words).
- MEM_LATENCY, 1, cycles from accepted request to SRAM read data valid; legal range 1..4.
- BASE_ADDR, 32'h1000_0000, byte base address of this bank; word-aligned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- tcdm_req_i  in  1  request valid.
- tcdm_add_i  in  32  byte address.
- tcdm_wen_i  in  1  0 = write, 1 = read.
- tcdm_wdata_i  in  32  write data.
- tcdm_be_i  in  4  byte enables.
- tcdm_gnt_o  out  1  request accepted this cycle.
- tcdm_r_rdata_o  out  32  read data.
- tcdm_r_opc_o  out  1  response error flag.
- tcdm_r_valid_o  out  1  response valid.
- mem_req_o  out  1  SRAM access request.
- mem_gnt_i  in  1  SRAM port available this cycle (bank shared with DMA side).
- mem_addr_o  out  MEM_ADDR_W  SRAM word address.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  4  SRAM byte enables.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data, valid MEM_LATENCY cycles after access.
- cnt_clr_i  in  1  synchronous clear of counters.
- rd_cnt_o  out  32  granted read count.
- wr_cnt_o  out  32  granted write count.

Behaviour:
- Handshake: a transfer occurs in any cycle with tcdm_req_i & tcdm_gnt_o.
  - tcdm_gnt_o = tcdm_req_i & mem_gnt_i, combinational.
  - Master holds request fields stable until granted.
  - One transfer per cycle; back-to-back transfers at full rate.
- SRAM drive, combinational from TCDM inputs:
  - mem_req_o = tcdm_req_i.
  - mem_we_o = ~tcdm_wen_i.
  - mem_be_o = tcdm_be_i.
  - mem_wdata_o = tcdm_wdata_i.
  - mem_addr_o = (tcdm_add_i - BASE_ADDR)[MEM_ADDR_W+1:2]; the two LSBs are ignored.
- Response pipeline: MEM_LATENCY-deep shift register of {valid, is_read, err}, loaded on each transfer and bubble-filled otherwise.
  - tcdm_r_valid_o is asserted exactly MEM_LATENCY cycles after the grant cycle, for both reads and writes.
  - Read: tcdm_r_rdata_o = mem_rdata_i in that cycle.
  - Write: tcdm_r_rdata_o = 0.
  - tcdm_r_opc_o = err stage bit; always 0 unless the optional feature is enabled.
  - tcdm_r_rdata_o = 0 when tcdm_r_valid_o = 0.
- No response backpressure: the master always accepts r_valid. Response order equals grant order.
- Counters:
  - rd_cnt_o +1 per granted read; wr_cnt_o +1 per granted write.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
  - cnt_clr_i forces both to 0 on the next edge and has priority over a same-cycle increment.
- Reset values: tcdm_r_valid_o = 0, tcdm_r_opc_o = 0, tcdm_r_rdata_o = 0, pipeline empty, rd_cnt_o = 0, wr_cnt_o = 0.
- Reset asserted mid-operation: all in-flight responses are dropped; no r_valid is produced for them after reset releases.
- mem_gnt_i low: no grant, no pipeline load, no counter change; the request remains pending.

Optional Feature:
- Macro: TCDM_SRAM_ADAPTER_RANGE_CHECK_EN.
- Enabled: an address outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_ADDR_W) is a range error.
  - tcdm_gnt_o = tcdm_req_i, regardless of mem_gnt_i.
  - mem_req_o = 0, so the SRAM is not accessed.
  - Response after MEM_LATENCY cycles with tcdm_r_opc_o = 1 and tcdm_r_rdata_o = 0.
  - Counters are not incremented.
- Disabled: no range check. Out-of-range addresses alias into the bank via the truncated offset, and tcdm_r_opc_o is tied to 0.

Test Plan:
- Write then read, MEM_LATENCY = 1: write add 0x1000_0010, wdata 0xDEADBEEF, be 0xF, then read same address -> mem_addr_o = 4 both times. Write response r_valid at T+1 with rdata 0; read r_valid at T+1 with rdata 0xDEADBEEF; wr_cnt_o = 1, rd_cnt_o = 1.
- Back-to-back reads, MEM_LATENCY = 3: 4 consecutive granted reads -> 4 consecutive r_valid pulses starting 3 cycles after the first grant, data in order.
- Stall: mem_gnt_i = 0 for 5 cycles with req held -> gnt_o = 0 and no r_valid during the stall. Grant in the cycle mem_gnt_i rises; response MEM_LATENCY cycles later.
- Counters: preload wr_cnt_o to 0xFFFF_FFFE via 2^32-2 writes (or force) plus 3 writes -> holds 0xFFFF_FFFF. cnt_clr_i together with a granted read -> rd_cnt_o = 0 next cycle.
- Reset mid-flight, MEM_LATENCY = 2: grant a read, assert rst_i the next cycle -> r_valid never asserts for it; all outputs 0 during reset.
- With TCDM_SRAM_ADAPTER_RANGE_CHECK_EN: read 0x2000_0000 -> immediate grant, mem_req_o = 0, r_valid after MEM_LATENCY with r_opc = 1 and rdata 0, rd_cnt_o unchanged.

Source files
------------

// File: rtl/tcdm_sram_adapter.sv
// TCDM slave endpoint driving one single-port SRAM bank, with a latency-matched response pipeline
// and saturating access counters. Optional range check: TCDM_SRAM_ADAPTER_RANGE_CHECK_EN.
module tcdm_sram_adapter #(
  parameter int unsigned MEM_ADDR_W  = 10,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tcdm_req_i,
  input  logic [31:0]           tcdm_add_i,
  input  logic                  tcdm_wen_i,
  input  logic [31:0]           tcdm_wdata_i,
  input  logic [3:0]            tcdm_be_i,
  output logic                  tcdm_gnt_o,
  output logic [31:0]           tcdm_r_rdata_o,
  output logic                  tcdm_r_opc_o,
  output logic                  tcdm_r_valid_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  cnt_clr_i,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
);

  logic [31:0] offset;
  logic        in_range;
  logic        xfer;
  logic        unused_bits;

  assign offset = tcdm_add_i - BASE_ADDR;

`ifdef TCDM_SRAM_ADAPTER_RANGE_CHECK_EN
  // Out-of-range requests are accepted immediately and answered with an error, never touching SRAM.
  assign in_range   = (offset >> (MEM_ADDR_W + 2)) == 32'd0;
  assign tcdm_gnt_o = tcdm_req_i & (mem_gnt_i | ~in_range);
  assign mem_req_o  = tcdm_req_i & in_range;
`else
  assign in_range   = 1'b1;
  assign tcdm_gnt_o = tcdm_req_i & mem_gnt_i;
  assign mem_req_o  = tcdm_req_i;
`endif

  assign unused_bits = ^{offset[31:MEM_ADDR_W+2], offset[1:0]};

  assign xfer        = tcdm_req_i & tcdm_gnt_o;
  assign mem_addr_o  = offset[MEM_ADDR_W+1:2];
  assign mem_we_o    = ~tcdm_wen_i;
  assign mem_be_o    = tcdm_be_i;
  assign mem_wdata_o = tcdm_wdata_i;

  // Response pipeline: stage 0 loads on the grant edge, last stage lines up with SRAM read data.
  logic [MEM_LATENCY-1:0] vld_q;
  logic [MEM_LATENCY-1:0] rd_q;
  logic [MEM_LATENCY-1:0] err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      rd_q  <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= xfer;
      rd_q[0]  <= xfer & tcdm_wen_i;
      err_q[0] <= xfer & ~in_range;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        rd_q[i]  <= rd_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign tcdm_r_valid_o = vld_q[MEM_LATENCY-1];
  assign tcdm_r_opc_o   = vld_q[MEM_LATENCY-1] & err_q[MEM_LATENCY-1];
  assign tcdm_r_rdata_o = (vld_q[MEM_LATENCY-1] & rd_q[MEM_LATENCY-1] & ~err_q[MEM_LATENCY-1]) ?
                          mem_rdata_i : 32'd0;

  // Saturating profiling counters; clear wins over a same-cycle increment.
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        rd_inc, wr_inc;

  assign rd_inc = xfer & in_range & tcdm_wen_i;
  assign wr_inc = xfer & in_range & ~tcdm_wen_i;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (cnt_clr_i) begin
      rd_cnt_d = 32'd0;
      wr_cnt_d = 32'd0;
    end else begin
      if (rd_inc && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
      if (wr_inc && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_tcdm_sram_adapter.sv
// Directed bench for tcdm_sram_adapter: two instances (latency 1 and 3) share one stimulus stream
// and one behavioural SRAM; expected values are hand-computed constants.
module tb_tcdm_sram_adapter;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req, wen, mem_gnt, cnt_clr;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  logic        gnt1, opc1, valid1, mreq1, mwe1;
  logic [31:0] rdata1, mwdata1, rd1, wr1;
  logic [9:0]  maddr1;
  logic [3:0]  mbe1;
  logic        gnt3, opc3, valid3, mreq3, mwe3;
  logic [31:0] rdata3, mwdata3, rd3, wr3;
  logic [9:0]  maddr3;
  logic [3:0]  mbe3;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_pipe [0:2];

  // Behavioural SRAM: write on granted access, read data delayed for each latency tap.
  always @(posedge clk) begin
    if (mreq1 && mem_gnt && mwe1) begin
      for (int b = 0; b < 4; b++) begin
        if (mbe1[b]) mem[maddr1][8*b +: 8] <= mwdata1[8*b +: 8];
      end
    end
    rd_pipe[0] <= mem[maddr1];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end

  tcdm_sram_adapter #(.MEM_ADDR_W(10), .MEM_LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_wdata_i(wdata), .tcdm_be_i(be), .tcdm_gnt_o(gnt1), .tcdm_r_rdata_o(rdata1),
    .tcdm_r_opc_o(opc1), .tcdm_r_valid_o(valid1), .mem_req_o(mreq1), .mem_gnt_i(mem_gnt),
    .mem_addr_o(maddr1), .mem_we_o(mwe1), .mem_be_o(mbe1), .mem_wdata_o(mwdata1),
    .mem_rdata_i(rd_pipe[0]), .cnt_clr_i(cnt_clr), .rd_cnt_o(rd1), .wr_cnt_o(wr1)
  );

  tcdm_sram_adapter #(.MEM_ADDR_W(10), .MEM_LATENCY(3), .BASE_ADDR(BASE)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_wdata_i(wdata), .tcdm_be_i(be), .tcdm_gnt_o(gnt3), .tcdm_r_rdata_o(rdata3),
    .tcdm_r_opc_o(opc3), .tcdm_r_valid_o(valid3), .mem_req_o(mreq3), .mem_gnt_i(mem_gnt),
    .mem_addr_o(maddr3), .mem_we_o(mwe3), .mem_be_o(mbe3), .mem_wdata_o(mwdata3),
    .mem_rdata_i(rd_pipe[2]), .cnt_clr_i(cnt_clr), .rd_cnt_o(rd3), .wr_cnt_o(wr3)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] b, input logic g, input logic c);
    @(negedge clk);
    req = r; add = a; wen = w; wdata = d; be = b; mem_gnt = g; cnt_clr = c;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; add = '0; wen = 1'b1; wdata = '0; be = '0;
    mem_gnt = 1'b1; cnt_clr = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid1", valid1, 0);
    check("rst_valid3", valid3, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_opc1", opc1, 0);
    check("rst_rdcnt1", rd1, 0);
    check("rst_wrcnt1", wr1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read the same word
    drive(1'b1, BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    check("wr_gnt1", gnt1, 1);
    check("wr_maddr1", maddr1, 4);
    check("wr_mreq1", mreq1, 1);
    check("wr_mwe1", mwe1, 1);
    check("wr_mwdata1", mwdata1, 32'hDEAD_BEEF);
    check("wr_mbe1", mbe1, 4'hF);
    check("wr_maddr3", maddr3, 4);
    check("wr_mwe3", mwe3, 1);
    check("wr_mwdata3", mwdata3, 32'hDEAD_BEEF);
    check("wr_mbe3", mbe3, 4'hF);
    check("wr_mreq3", mreq3, 1);
    drive(1'b1, BASE + 32'h10, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0);
    check("wresp_valid1", valid1, 1);
    check("wresp_rdata1", rdata1, 0);
    check("wresp_wrcnt1", wr1, 1);
    check("rd_maddr1", maddr1, 4);
    check("rd_mwe1", mwe1, 0);
    check("wresp_valid3_early", valid3, 0);
    nop();
    check("rresp_valid1", valid1, 1);
    check("rresp_rdata1", rdata1, 32'hDEAD_BEEF);
    check("rresp_rdcnt1", rd1, 1);
    check("rdcnt3", rd3, 1);
    check("wrcnt3", wr3, 1);
    nop();
    check("idle_valid1", valid1, 0);
    check("idle_rdata1", rdata1, 0);
    check("wresp_valid3", valid3, 1);
    check("wresp_rdata3", rdata3, 0);
    nop();
    check("rresp_valid3", valid3, 1);
    check("rresp_rdata3", rdata3, 32'hDEAD_BEEF);
    nop();
    check("idle_valid3", valid3, 0);

    // Back-to-back: four writes, drain, four reads
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, BASE + 32'(4 * i), 1'b0, 32'hA000_0000 + 32'(i), 4'hF, 1'b1, 1'b0);
    end
    repeat (4) nop();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, BASE + 32'(4 * c), 1'b1, 32'h0, 4'hF, 1'b1, 1'b0);
      else nop();
      check($sformatf("b2b_v1_%0d", c), valid1, (c >= 1 && c <= 4) ? 1 : 0);
      check($sformatf("b2b_d1_%0d", c), rdata1,
            (c >= 1 && c <= 4) ? 32'hA000_0000 + 32'(c - 1) : 32'h0);
      check($sformatf("b2b_v3_%0d", c), valid3, (c >= 3 && c <= 6) ? 1 : 0);
      check($sformatf("b2b_d3_%0d", c), rdata3,
            (c >= 3 && c <= 6) ? 32'hA000_0000 + 32'(c - 3) : 32'h0);
    end
    check("b2b_rdcnt1", rd1, 5);
    check("b2b_wrcnt1", wr1, 5);

    // Stall: request held while the SRAM port is busy
    repeat (4) nop();
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, BASE + 32'h8, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
      check($sformatf("stall_gnt1_%0d", s), gnt1, 0);
      check($sformatf("stall_gnt3_%0d", s), gnt3, 0);
      check($sformatf("stall_valid_%0d", s), valid1 | valid3, 0);
    end
    check("stall_rdcnt1", rd1, 5);
    drive(1'b1, BASE + 32'h8, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0);
    check("unstall_gnt1", gnt1, 1);
    nop();
    check("unstall_valid1", valid1, 1);
    check("unstall_rdata1", rdata1, 32'hA000_0002);
    check("unstall_rdcnt1", rd1, 6);
    nop();
    check("unstall_valid3_early", valid3, 0);
    nop();
    check("unstall_valid3", valid3, 1);
    check("unstall_rdata3", rdata3, 32'hA000_0002);

    // Counter saturation and clear priority
    repeat (2) nop();
    force u_dut1.wr_cnt_q = 32'hFFFF_FFFE;
    force u_dut3.wr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut1.wr_cnt_q;
    release u_dut3.wr_cnt_q;
    check("preload_wrcnt1", wr1, 32'hFFFF_FFFE);
    drive(1'b1, BASE + 32'h100, 1'b0, 32'h5555_5555, 4'b0101, 1'b1, 1'b0);
    check("part_mbe1", mbe1, 4'b0101);
    drive(1'b1, BASE + 32'h100, 1'b0, 32'h5555_5555, 4'b0101, 1'b1, 1'b0);
    check("sat_wrcnt1_a", wr1, 32'hFFFF_FFFF);
    drive(1'b1, BASE + 32'h100, 1'b0, 32'h5555_5555, 4'b0101, 1'b1, 1'b0);
    nop();
    check("sat_wrcnt1_b", wr1, 32'hFFFF_FFFF);
    check("sat_wrcnt3", wr3, 32'hFFFF_FFFF);
    drive(1'b1, BASE, 1'b1, 32'h0, 4'hF, 1'b1, 1'b1);
    nop();
    check("clr_rdcnt1", rd1, 0);
    check("clr_wrcnt1", wr1, 0);
    check("clr_rdcnt3", rd3, 0);
    drive(1'b1, BASE, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0);
    nop();
    check("post_clr_rdcnt1", rd1, 1);

    // Reset while a read is in flight
    repeat (4) nop();
    drive(1'b1, BASE + 32'h4, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    #1;
    check("mid_rst_valid1", valid1, 0);
    check("mid_rst_valid3", valid3, 0);
    check("mid_rst_rdata1", rdata1, 0);
    check("mid_rst_rdata3", rdata3, 0);
    check("mid_rst_opc", opc1 | opc3, 0);
    check("mid_rst_rdcnt1", rd1, 0);
    check("mid_rst_wrcnt1", wr1, 0);
    check("mid_rst_rdcnt3", rd3, 0);
    check("mid_rst_gnt1", gnt1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nop();
      check($sformatf("post_rst_valid_%0d", k), valid1 | valid3, 0);
    end

`ifdef TCDM_SRAM_ADAPTER_RANGE_CHECK_EN
    // Out-of-range read: immediate grant, no SRAM access, error response
    drive(1'b1, 32'h2000_0000, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
    check("oor_gnt1", gnt1, 1);
    check("oor_gnt3", gnt3, 1);
    check("oor_mreq1", mreq1, 0);
    nop();
    check("oor_valid1", valid1, 1);
    check("oor_opc1", opc1, 1);
    check("oor_rdata1", rdata1, 0);
    check("oor_rdcnt1", rd1, 0);
    nop();
    nop();
    check("oor_valid3", valid3, 1);
    check("oor_opc3", opc3, 1);
    check("oor_rdata3", rdata3, 0);
`else
    // Out-of-range read aliases onto word 0 and follows the normal handshake
    drive(1'b1, 32'h2000_0000, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
    check("alias_gnt1_busy", gnt1, 0);
    check("alias_mreq1", mreq1, 1);
    check("alias_maddr1", maddr1, 0);
    drive(1'b1, 32'h2000_0000, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0);
    check("alias_gnt1", gnt1, 1);
    nop();
    check("alias_valid1", valid1, 1);
    check("alias_opc1", opc1, 0);
    check("alias_rdata1", rdata1, 32'hA000_0000);
    check("alias_rdcnt1", rd1, 1);
    nop();
    nop();
    check("alias_valid3", valid3, 1);
    check("alias_opc3", opc3, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
